mem_moc_ram: RTL and testbench

- Byte-addressed, big-endian instruction/data memory for the multicycle MIPS datapath.
- The control unit's memory states drive it through a four-phase MFA/MOC (memory function activate / memory operation complete) handshake.
- Serves IR fetches and load/store data with a fixed, parameterised access latency.
- The byte array stays hierarchically preloadable by the bench, and reset never clears it.

---
 rtl/mips_mem_pkg.sv | 29 ++
 rtl/mem_align_unit.sv | 51 +++++
 rtl/mem_moc_ram.sv | 144 ++++++++++++++
 tb/tb_mem_moc_ram.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared encodings for the multicycle MIPS memory: access sizes, direction and FSM states.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic misaligned(input size_e sz, input logic [1:0] lsb);
        unique case (sz)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lsb[0];
            SZ_WORD: misaligned = (lsb != 2'b00);
            default: misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational alignment check, big-endian lane steering and read extension.
// Lane k always refers to byte address a+k, so lane 0 is the most significant byte.
module mem_align_unit
    import mips_mem_pkg::*;
(
    input  size_e            i_size,
    input  logic             i_se,
    input  logic [1:0]       i_addr_lsb,
    input  logic [3:0][7:0]  i_rd_bytes,
    input  logic [31:0]      i_wr_data,
    output logic             o_err,
    output logic [31:0]      o_rd_data,
    output logic [3:0]       o_wr_en,
    output logic [3:0][7:0]  o_wr_bytes
);

    logic w_sign;

    always_comb begin
        o_err      = misaligned(i_size, i_addr_lsb);
        w_sign     = i_se & i_rd_bytes[0][7];
        o_rd_data  = '0;
        o_wr_en    = '0;
        o_wr_bytes = '0;
        case (i_size)
            SZ_BYTE: begin
                o_rd_data     = {{24{w_sign}}, i_rd_bytes[0]};
                o_wr_en       = 4'b0001;
                o_wr_bytes[0] = i_wr_data[7:0];
            end
            SZ_HALF: begin
                o_rd_data     = {{16{w_sign}}, i_rd_bytes[0], i_rd_bytes[1]};
                o_wr_en       = 4'b0011;
                o_wr_bytes[0] = i_wr_data[15:8];
                o_wr_bytes[1] = i_wr_data[7:0];
            end
            SZ_WORD: begin
                o_rd_data     = {i_rd_bytes[0], i_rd_bytes[1], i_rd_bytes[2], i_rd_bytes[3]};
                o_wr_en       = 4'b1111;
                o_wr_bytes[0] = i_wr_data[31:24];
                o_wr_bytes[1] = i_wr_data[23:16];
                o_wr_bytes[2] = i_wr_data[15:8];
                o_wr_bytes[3] = i_wr_data[7:0];
            end
            default: ;
        endcase
        if (o_err)
            o_wr_en = '0;
    end

endmodule

// File: rtl/mem_moc_ram.sv
// Byte-addressed big-endian memory with a four-phase MFA/MOC handshake and fixed access latency.
module mem_moc_ram
    import mips_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 2
) (
    input  logic                  Clk,
    input  logic                  Clear,
    input  logic                  MFA,
    input  logic                  RW,
    input  logic [1:0]            Size,
    input  logic                  SE,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic [31:0]           DataIn,
    output logic [31:0]           DataOut,
    output logic                  MOC,
    output logic                  ERR
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [7:0] Mem [0:DEPTH-1];

    state_e                r_state;
    state_e                w_next;
    logic [CW-1:0]         r_cnt;
    logic                  r_rw;
    logic                  r_se;
    size_e                 r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_din;
    logic                  r_moc;
    logic                  r_err;
    logic [31:0]           r_dout;

    logic                  w_capture;
    logic                  w_access;
    logic [3:0][7:0]       w_rd_bytes;
    logic [3:0][7:0]       w_wr_bytes;
    logic [3:0]            w_wr_en;
    logic                  w_err;
    logic [31:0]           w_rd_data;

    always_comb begin
        for (int unsigned k = 0; k < 4; k++)
            w_rd_bytes[k] = Mem[r_addr + ADDR_WIDTH'(k)];
    end

    mem_align_unit u_align (
        .i_size     (r_size),
        .i_se       (r_se),
        .i_addr_lsb (r_addr[1:0]),
        .i_rd_bytes (w_rd_bytes),
        .i_wr_data  (r_din),
        .o_err      (w_err),
        .o_rd_data  (w_rd_data),
        .o_wr_en    (w_wr_en),
        .o_wr_bytes (w_wr_bytes)
    );

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_capture = 1'b0;
        w_access  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (MFA) begin
                    w_capture = 1'b1;
                    w_next    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_access = 1'b1;
                    w_next   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!MFA)
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            r_cnt  <= '0;
            r_rw   <= RW_READ;
            r_se   <= 1'b0;
            r_size <= SZ_BYTE;
            r_addr <= '0;
            r_din  <= '0;
            r_moc  <= 1'b0;
            r_err  <= 1'b0;
            r_dout <= '0;
        end else begin
            if (w_capture) begin
                r_rw   <= RW;
                r_se   <= SE;
                r_size <= size_e'(Size);
                r_addr <= Address;
                r_din  <= DataIn;
                r_cnt  <= CW'(LATENCY - 1);
            end else if (r_state == ST_BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_access) begin
                r_moc <= 1'b1;
                r_err <= w_err;
                if (!w_err && r_rw == RW_READ)
                    r_dout <= w_rd_data;
            end else if (r_state == ST_DONE && !MFA) begin
                r_moc <= 1'b0;
                r_err <= 1'b0;
            end
        end
    end

    // No reset on the array: contents survive Clear and stay preloadable from the bench.
    always_ff @(posedge Clk) begin
        if (w_access && !Clear && r_rw == RW_WRITE) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (w_wr_en[k])
                    Mem[r_addr + ADDR_WIDTH'(k)] <= w_wr_bytes[k];
            end
        end
    end

    assign DataOut = r_dout;
    assign MOC     = r_moc;
    assign ERR     = r_err;

endmodule

// File: tb/tb_mem_moc_ram.sv
// Randomised handshake bench for mem_moc_ram with a transaction-timestamp reference model.
module tb_mem_moc_ram;

    localparam int AW    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic          Clk = 1'b0;
    logic          Clear = 1'b1;
    logic          MFA = 1'b0;
    logic          RW = 1'b1;
    logic [1:0]    Size = 2'b00;
    logic          SE = 1'b0;
    logic [AW-1:0] Address = '0;
    logic [31:0]   DataIn = '0;
    logic [31:0]   DataOut;
    logic          MOC;
    logic          ERR;

    mem_moc_ram #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .Clk     (Clk),
        .Clear   (Clear),
        .MFA     (MFA),
        .RW      (RW),
        .Size    (Size),
        .SE      (SE),
        .Address (Address),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .MOC     (MOC),
        .ERR     (ERR)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    logic [7:0] mm  [DEPTH];
    logic [7:0] pre [DEPTH];

    // Reference model: phase 0 idle, 1 waiting for the due edge, 2 complete
    int          edge_no = 0;
    int          m_phase = 0;
    int          m_due = 0;
    logic        m_rw, m_se;
    int          m_size, m_addr;
    logic [31:0] m_din;
    logic        exp_moc = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_dout = '0;

    task automatic model_access();
        int n;
        logic [31:0] val;
        n = 1 << m_size;
        if (m_size == 3 || (m_addr % n) != 0) begin
            exp_err = 1'b1;
        end else begin
            exp_err = 1'b0;
            if (m_rw) begin
                val = '0;
                for (int i = 0; i < n; i++)
                    val = (val << 8) | 32'(mm[m_addr + i]);
                if (n < 4 && m_se && val[8*n-1])
                    val = val | (32'hFFFF_FFFF << (8 * n));
                exp_dout = val;
            end else begin
                for (int i = 0; i < n; i++)
                    mm[m_addr + i] = 8'(m_din >> (8 * (n - 1 - i)));
            end
        end
    endtask

    always @(posedge Clk or posedge Clear) begin
        if (Clear) begin
            m_phase  = 0;
            exp_moc  = 1'b0;
            exp_err  = 1'b0;
            exp_dout = '0;
        end else begin
            edge_no++;
            if (m_phase == 0) begin
                if (MFA) begin
                    m_rw   = RW;
                    m_se   = SE;
                    m_size = int'(Size);
                    m_addr = int'(Address);
                    m_din  = DataIn;
                    m_due  = edge_no + LAT;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (edge_no == m_due) begin
                    model_access();
                    exp_moc = 1'b1;
                    m_phase = 2;
                end
            end else if (!MFA) begin
                exp_moc = 1'b0;
                exp_err = 1'b0;
                m_phase = 0;
            end
        end
    end

    always @(negedge Clk) begin
        if (cmp_en && !Clear) begin
            checks++;
            if (MOC !== exp_moc) begin
                errors++;
                $display("FAIL moc t=%0t actual %b required %b", $time, MOC, exp_moc);
            end
            checks++;
            if (ERR !== exp_err) begin
                errors++;
                $display("FAIL err t=%0t actual %b required %b", $time, ERR, exp_err);
            end
            checks++;
            if (DataOut !== exp_dout) begin
                errors++;
                $display("FAIL dout t=%0t actual %h required %h", $time, DataOut, exp_dout);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic do_req(input logic rw, input logic [1:0] sz, input logic se, input int addr,
                          input logic [31:0] din, input int hold, input bit drop,
                          output int lat, output logic [31:0] dout, output logic err);
        int n;
        bit got;
        @(negedge Clk);
        RW = rw; Size = sz; SE = se; Address = AW'(addr); DataIn = din; MFA = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge Clk);
            n++;
            @(negedge Clk);
            if (n == 1) begin
                // Scramble request lines after capture; the access must use the latched copy
                Address = AW'($urandom); DataIn = $urandom; RW = 1'($urandom);
                Size = 2'($urandom); SE = 1'($urandom);
                if (drop) MFA = 1'b0;
            end
            if (MOC) got = 1'b1;
        end
        lat  = n - 1;
        dout = DataOut;
        err  = ERR;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL moc_timeout actual 0 required 1");
            MFA = 1'b0;
        end else begin
            repeat (hold) @(negedge Clk);
            MFA = 1'b0;
            n = 0;
            while (MOC && n < 10) begin
                @(negedge Clk);
                n++;
            end
            check("moc_release", 32'(MOC), 32'd0);
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] d, prior;
        logic        e;
        int          cnt;
        int          sz, a, hold;
        bit          drop;

        #1;
        for (int i = 0; i < DEPTH; i++) pre[i] = 8'($urandom);
        pre[0] = 8'h8C; pre[1] = 8'h01; pre[2] = 8'h00; pre[3] = 8'h04;
        for (int i = 0; i < DEPTH; i++) begin
            mm[i] = pre[i];
            dut.Mem[i] = pre[i];
        end

        repeat (2) @(negedge Clk);
        check("rst_moc",  32'(MOC), 32'd0);
        check("rst_err",  32'(ERR), 32'd0);
        check("rst_dout", DataOut, 32'd0);
        Clear = 1'b0;
        cmp_en = 1'b1;
        check("preload_0", 32'(dut.Mem[0]), 32'h8C);

        do_req(1'b1, 2'b10, 1'b0, 0, 32'd0, 0, 1'b0, lat, d, e);
        check("word0_lat", 32'(lat), 32'(LAT));
        check("word0_dout", d, 32'h8C01_0004);
        check("word0_err", 32'(e), 32'd0);

        do_req(1'b0, 2'b00, 1'b0, 9, 32'hFFFF_FFA5, 0, 1'b0, lat, d, e);
        check("bw_lat", 32'(lat), 32'(LAT));
        do_req(1'b1, 2'b00, 1'b1, 9, 32'd0, 0, 1'b0, lat, d, e);
        check("lb_sext", d, 32'hFFFF_FFA5);
        do_req(1'b1, 2'b00, 1'b0, 9, 32'd0, 0, 1'b0, lat, d, e);
        check("lbu_zext", d, 32'h0000_00A5);
        check("mem8",  32'(dut.Mem[8]),  32'(pre[8]));
        check("mem10", 32'(dut.Mem[10]), 32'(pre[10]));

        do_req(1'b0, 2'b01, 1'b0, 6, 32'h0000_BEEF, 0, 1'b0, lat, d, e);
        do_req(1'b1, 2'b10, 1'b0, 4, 32'd0, 0, 1'b0, lat, d, e);
        prior = {pre[4], pre[5], 8'hBE, 8'hEF};
        check("half_then_word", d, prior);

        do_req(1'b1, 2'b10, 1'b0, 2, 32'd0, 0, 1'b0, lat, d, e);
        check("mis_word_err", 32'(e), 32'd1);
        check("mis_word_dout", d, prior);
        do_req(1'b0, 2'b01, 1'b0, 5, 32'h0000_1234, 0, 1'b0, lat, d, e);
        check("mis_half_err", 32'(e), 32'd1);
        check("mis_half_mem5", 32'(dut.Mem[5]), 32'(pre[5]));
        check("mis_half_mem6", 32'(dut.Mem[6]), 32'hBE);
        do_req(1'b1, 2'b11, 1'b0, 8, 32'd0, 0, 1'b0, lat, d, e);
        check("rsvd_err", 32'(e), 32'd1);
        check("rsvd_dout", d, prior);

        do_req(1'b1, 2'b10, 1'b0, 0, 32'd0, 5, 1'b0, lat, d, e);
        check("hold_dout", d, 32'h8C01_0004);
        check("hold_persist", DataOut, 32'h8C01_0004);

        @(negedge Clk);
        RW = 1'b1; Size = 2'b01; SE = 1'b1; Address = 8'd0; MFA = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        MFA = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge Clk);
            if (MOC) cnt++;
        end
        check("pulse_width", 32'(cnt), 32'd1);
        check("pulse_dout", DataOut, 32'hFFFF_8C01);

        @(negedge Clk);
        RW = 1'b0; Size = 2'b10; Address = 8'd16; DataIn = 32'hDEAD_BEEF; MFA = 1'b1;
        @(posedge Clk);
        #1;
        Clear = 1'b1;
        MFA = 1'b0;
        #1;
        check("abort_moc", 32'(MOC), 32'd0);
        check("abort_dout", DataOut, 32'd0);
        check("abort_state", 32'(dut.r_state), 32'd0);
        repeat (3) @(negedge Clk);
        Clear = 1'b0;
        repeat (4) @(negedge Clk);
        for (int i = 16; i < 20; i++)
            check("abort_mem", 32'(dut.Mem[i]), 32'(pre[i]));

        for (int t = 0; t < 150; t++) begin
            sz = $urandom_range(0, 3);
            a  = $urandom_range(0, DEPTH - 1);
            if (sz < 3 && $urandom_range(0, 3) != 0)
                a = a & ~((1 << sz) - 1);
            hold = $urandom_range(0, 3);
            drop = ($urandom_range(0, 4) == 0);
            if (drop) hold = 0;
            do_req(1'($urandom), 2'(sz), 1'($urandom), a, $urandom, hold, drop, lat, d, e);
            check("rand_lat", 32'(lat), 32'(LAT));
        end

        repeat (2) @(negedge Clk);
        cmp_en = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            check("final_mem", 32'(dut.Mem[i]), 32'(mm[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
